adder_engine: RTL and testbench
===============================

ADDER_ENGINE -- requirements
Module: adder_engine

Interface
REQ-001 The block SHALL have parameter SLICE_W, default 8, giving the width in bits of the operand slice added per cycle; legal values are 8, 16 and 32.
REQ-002 The block SHALL have port clk, input, 1 bit: clock; all state is updated on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port augend, input, 32 bits: first operand, from the register-file AUGEND register.
REQ-005 The block SHALL have port addend, input, 32 bits: second operand, from the register-file ADDEND register.
REQ-006 The block SHALL have port ctrl, input, 32 bits: control word; bit 0 is START (level) and bit 1 is CLEAR; all other bits are ignored.
REQ-007 The block SHALL have port sum, output, 32 bits: result register, read back through the SUM register.
REQ-008 The block SHALL have port ofsign, output, 32 bits: status word with bit 0 OVF (signed overflow), bit 1 CARRY (carry out of bit 31), bit 2 SIGN (sum[31]), bit 3 ZERO, bit 8 BUSY and bit 9 DONE; all other bits read 0.

Function
REQ-009 The block SHALL implement a state machine with states IDLE and CALC.
REQ-010 The block SHALL register START every cycle into start_q; a start event is the condition ctrl[0]==1 and start_q==0.
REQ-011 On the edge where a start event occurs in IDLE with CLEAR==0 (edge E0), the block SHALL:
- snapshot augend and addend into internal operand registers;
- clear slice index, carry register and accumulator;
- set BUSY=1 and DONE=0;
- enter CALC.
REQ-012 In CALC, at each edge Ek (k=1..N, N=32/SLICE_W), the block SHALL:
- add slice k-1 of both snapshots plus the carry register;
- write the SLICE_W-bit result into accumulator slice k-1;
- store the carry-out into the carry register.
REQ-013 At edge EN the block SHALL:
- load sum with the completed accumulator value;
- set CARRY to the final carry;
- set OVF to (a[31]==b[31]) and (sum[31]!=a[31]);
- set SIGN and ZERO from the new sum;
- set BUSY=0 and DONE=1;
- return to IDLE.
REQ-014 Latency SHALL be exactly N cycles from E0 to valid sum/ofsign (4 cycles for SLICE_W=8); sum and the flags SHALL NOT change during CALC.
REQ-015 Changes on augend/addend after E0 SHALL NOT affect the result in progress.
REQ-016 A start event in CALC SHALL be ignored; START held high SHALL cause exactly one calculation.
REQ-017 When CLEAR==1 at an edge, in any state, the block SHALL:
- clear sum and all ofsign bits;
- return to IDLE;
- abort any calculation in progress.
CLEAR SHALL take priority over a simultaneous start event.
REQ-018 DONE SHALL hold until the next start event or CLEAR; results SHALL hold until the next completion or CLEAR.
REQ-019 Arithmetic SHALL be unsigned 32-bit modulo 2^32; OVF interprets the operands as two's-complement values.

Reset
REQ-020 On rst_n low the block SHALL asynchronously set:
- state to IDLE;
- sum, ofsign, the snapshots, accumulator, carry, slice index and start_q to 0.
REQ-021 Reset asserted mid-CALC SHALL abort the calculation with no partial result visible.
REQ-022 After reset release, a START already high SHALL count as a start event on the first edge.

Structure
REQ-023 The CTRL and OFSIGN bit positions and the state encodings SHALL be defined in a shared header, adder_defs.vh, shared with the register-file slave.
REQ-024 The per-slice add SHALL be one combinational sub-module, adder_slice (SLICE_W-bit a, b, cin; outputs s and cout), instantiated once.

Verification
REQ-025 The bench SHALL cover: 0x7FFFFFFF + 0x00000001, START pulse -> after 4 cycles, sum=0x80000000, OVF=1, CARRY=0, SIGN=1, ZERO=0, DONE=1.
REQ-026 The bench SHALL cover: 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, CARRY=1, ZERO=1, OVF=0; BUSY=1 on cycles 1-4 only.
REQ-027 The bench SHALL cover: 0x12345678 + 0x11111111 with augend changed to 0 one cycle after E0 -> sum=0x23456789.
REQ-028 The bench SHALL cover: CLEAR asserted at E2 of a calculation -> sum=0, ofsign=0, state IDLE; a new START edge then completes normally.
REQ-029 The bench SHALL cover: START held high for 20 cycles -> exactly one completion (one BUSY pulse of 4 cycles).
REQ-030 The bench SHALL cover: rst_n pulsed low at E3 -> all outputs 0 immediately; no completion follows until a new START edge.

Source files
------------

// File: rtl/adder_engine_pkg.sv
// ---------------------------------------------------------------------------
// adder_engine_pkg
// Shared definitions for the adder engine and its register-file slave:
//   - CTRL word bit positions (START, CLEAR)
//   - OFSIGN status word bit positions (OVF, CARRY, SIGN, ZERO, BUSY, DONE)
//   - FSM state encodings
//   - helper to assemble the OFSIGN word from individual flags
// ---------------------------------------------------------------------------
package adder_engine_pkg;

    // CTRL register bits
    localparam int CTRL_START = 0;
    localparam int CTRL_CLEAR = 1;

    // OFSIGN register bits
    localparam int OFS_OVF   = 0;
    localparam int OFS_CARRY = 1;
    localparam int OFS_SIGN  = 2;
    localparam int OFS_ZERO  = 3;
    localparam int OFS_BUSY  = 8;
    localparam int OFS_DONE  = 9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_e;

    // Unlisted bits read as 0.
    function automatic logic [31:0] pack_ofsign(input logic ovf, input logic carry,
                                                input logic sign, input logic zero,
                                                input logic busy, input logic done);
        logic [31:0] w;
        w            = '0;
        w[OFS_OVF]   = ovf;
        w[OFS_CARRY] = carry;
        w[OFS_SIGN]  = sign;
        w[OFS_ZERO]  = zero;
        w[OFS_BUSY]  = busy;
        w[OFS_DONE]  = done;
        return w;
    endfunction

endpackage

// File: rtl/adder_engine_if.sv
// ---------------------------------------------------------------------------
// adder_engine_if
// Register-file side bus of the adder engine.
//   augend, addend : operands (AUGEND / ADDEND registers)
//   ctrl           : control word (bit0 START level, bit1 CLEAR)
//   sum            : result (SUM register)
//   ofsign         : status word (OVF/CARRY/SIGN/ZERO/BUSY/DONE)
// master = register-file side, slave = engine side.
// ---------------------------------------------------------------------------
interface adder_engine_if;
    logic [31:0] augend;
    logic [31:0] addend;
    logic [31:0] ctrl;
    logic [31:0] sum;
    logic [31:0] ofsign;

    modport master (output augend, addend, ctrl, input sum, ofsign);
    modport slave  (input augend, addend, ctrl, output sum, ofsign);
endinterface

// File: rtl/adder_slice.sv
// ---------------------------------------------------------------------------
// adder_slice
// Combinational SLICE_W-bit adder with carry in/out.
//   a, b : slice operands
//   cin  : carry in
//   s    : slice sum
//   cout : carry out
// ---------------------------------------------------------------------------
module adder_slice #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
endmodule

// File: rtl/adder_engine.sv
// ---------------------------------------------------------------------------
// adder_engine
// Multi-cycle 32-bit adder: adds one SLICE_W-bit slice per cycle, so a
// result takes N = 32/SLICE_W cycles after the start edge.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : adder_engine_if.slave (augend/addend/ctrl in, sum/ofsign out)
// sum and the flags are only written on completion or CLEAR, so they stay
// stable while a calculation is running.
// ---------------------------------------------------------------------------
module adder_engine
    import adder_engine_pkg::*;
#(
    parameter int SLICE_W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    adder_engine_if.slave  bus
);
    localparam int N     = 32 / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    state_e                    state_q;
    logic                      start_q;
    logic [N-1:0][SLICE_W-1:0] a_q, b_q, acc_q;
    logic                      carry_q;
    logic [IDX_W-1:0]          idx_q;
    logic [31:0]               sum_q;
    logic                      ovf_q, cflag_q, sign_q, zero_q, busy_q, done_q;

    logic                      start, clear, start_ev;
    logic [SLICE_W-1:0]        s_sl;
    logic                      cout_sl;
    logic [N-1:0][SLICE_W-1:0] acc_d;
    logic [31:0]               acc_flat;
    logic                      unused_ctrl;

    assign start       = bus.ctrl[CTRL_START];
    assign clear       = bus.ctrl[CTRL_CLEAR];
    assign start_ev    = start & ~start_q;
    assign unused_ctrl = ^bus.ctrl[31:2];

    adder_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .cin  (carry_q),
        .s    (s_sl),
        .cout (cout_sl)
    );

    // Accumulator with the current slice merged in; on the last slice this
    // is the complete result.
    always_comb begin
        acc_d        = acc_q;
        acc_d[idx_q] = s_sl;
        acc_flat     = acc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cflag_q <= 1'b0;
            sign_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            start_q <= start;
            if (clear) begin
                // CLEAR wins over a simultaneous start event.
                state_q <= ST_IDLE;
                sum_q   <= '0;
                ovf_q   <= 1'b0;
                cflag_q <= 1'b0;
                sign_q  <= 1'b0;
                zero_q  <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_ev) begin
                            a_q     <= bus.augend;
                            b_q     <= bus.addend;
                            acc_q   <= '0;
                            carry_q <= 1'b0;
                            idx_q   <= '0;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            state_q <= ST_CALC;
                        end
                    end
                    ST_CALC: begin
                        // Start events are ignored here.
                        acc_q   <= acc_d;
                        carry_q <= cout_sl;
                        idx_q   <= idx_q + IDX_W'(1);
                        if (idx_q == IDX_LAST) begin
                            sum_q   <= acc_flat;
                            cflag_q <= cout_sl;
                            ovf_q   <= (a_q[N-1][SLICE_W-1] == b_q[N-1][SLICE_W-1]) &&
                                       (acc_flat[31] != a_q[N-1][SLICE_W-1]);
                            sign_q  <= acc_flat[31];
                            zero_q  <= (acc_flat == 32'd0);
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.sum    = sum_q;
    assign bus.ofsign = pack_ofsign(ovf_q, cflag_q, sign_q, zero_q, busy_q, done_q);

endmodule

// File: tb/tb_adder_engine.sv
// ---------------------------------------------------------------------------
// tb_adder_engine
// Directed bench for adder_engine (SLICE_W=8). Expected results come from a
// 33-bit reference add and are queued when a calculation is started, then
// popped when DONE is seen.
// ---------------------------------------------------------------------------
module tb_adder_engine;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] ofsign;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    exp_t sb[$];

    adder_engine_if bus ();

    adder_engine #(.SLICE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [32:0] r;
        r        = {1'b0, a} + {1'b0, b};
        e.sum    = r[31:0];
        e.ofsign = 32'h0000_0200;                       // DONE
        if (a[31] == b[31] && r[31] != a[31]) e.ofsign[0] = 1'b1;
        if (r[32])                            e.ofsign[1] = 1'b1;
        if (r[31])                            e.ofsign[2] = 1'b1;
        if (r[31:0] == 32'd0)                 e.ofsign[3] = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives a START pulse, optionally zeroes augend after E0, then waits
    // (bounded) for DONE and checks latency, BUSY width, sum stability and result.
    task automatic run_calc(input string tag, input logic [31:0] a,
                            input logic [31:0] b, input bit zap_a);
        int          lat, busy_n;
        logic        stable;
        logic [31:0] prev;
        exp_t        e;
        bus.augend = a;
        bus.addend = b;
        bus.ctrl   = 32'h1;
        sb.push_back(model(a, b));
        prev = bus.sum;
        step();                                         // E0
        bus.ctrl = 32'h0;
        if (zap_a) bus.augend = 32'h0;
        lat = 0; busy_n = 0; stable = 1'b1;
        while (!bus.ofsign[9] && lat < 12) begin
            if (bus.ofsign[8]) busy_n++;
            if (bus.sum !== prev) stable = 1'b0;
            step();
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " busy_cycles"}, 32'(busy_n), 32'd4);
        chk({tag, " sum_stable"}, {31'd0, stable}, 32'd1);
        chk({tag, " sb_nonempty"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, " sum"}, bus.sum, e.sum);
            chk({tag, " ofsign"}, bus.ofsign, e.ofsign);
        end
    endtask

    initial begin
        int   busy_n, rises;
        logic prev_done, quiet;
        exp_t e;

        rst_n      = 1'b0;
        bus.augend = 32'h0;
        bus.addend = 32'h0;
        bus.ctrl   = 32'h0;
        #12;
        chk("reset sum", bus.sum, 32'h0);
        chk("reset ofsign", bus.ofsign, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Signed overflow into the sign bit.
        run_calc("ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
        chk("ovf const sum", bus.sum, 32'h8000_0000);
        chk("ovf const ofsign", bus.ofsign, 32'h0000_0205);
        step();

        // Unsigned wrap to zero.
        run_calc("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        chk("wrap const ofsign", bus.ofsign, 32'h0000_020A);
        step();

        // Operand change after E0 must not matter.
        run_calc("snap", 32'h1234_5678, 32'h1111_1111, 1'b1);
        chk("snap const sum", bus.sum, 32'h2345_6789);
        step();

        // CLEAR sampled at E2 aborts the calculation.
        bus.augend = 32'h1;
        bus.addend = 32'h2;
        bus.ctrl   = 32'h1;
        step();                                         // E0
        bus.ctrl = 32'h0;
        step();                                         // E1
        bus.ctrl = 32'h2;
        step();                                         // E2
        chk("clear sum", bus.sum, 32'h0);
        chk("clear ofsign", bus.ofsign, 32'h0);
        bus.ctrl = 32'h0;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.ofsign !== 32'h0 || bus.sum !== 32'h0) quiet = 1'b0;
        end
        chk("clear stays idle", {31'd0, quiet}, 32'd1);
        run_calc("after_clear", 32'h8000_0000, 32'h8000_0000, 1'b0);
        chk("after_clear const ofsign", bus.ofsign, 32'h0000_020B);
        step();

        // START held for 20 cycles -> exactly one calculation.
        bus.augend = 32'h0000_0005;
        bus.addend = 32'hFFFF_FFFE;
        bus.ctrl   = 32'h1;
        sb.push_back(model(32'h0000_0005, 32'hFFFF_FFFE));
        busy_n = 0; rises = 0; prev_done = bus.ofsign[9];
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.ofsign[8]) busy_n++;
            if (bus.ofsign[9] && !prev_done) rises++;
            prev_done = bus.ofsign[9];
        end
        bus.ctrl = 32'h0;
        chk("held busy_cycles", 32'(busy_n), 32'd4);
        chk("held completions", 32'(rises), 32'd1);
        chk("held sb_nonempty", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("held sum", bus.sum, e.sum);
            chk("held ofsign", bus.ofsign, e.ofsign);
        end
        step();

        // Reset pulsed at E3 of a calculation.
        bus.augend = 32'h11;
        bus.addend = 32'h22;
        bus.ctrl   = 32'h1;
        step();                                         // E0
        bus.ctrl = 32'h0;
        step();                                         // E1
        step();                                         // E2
        @(posedge clk);                                 // E3
        rst_n = 1'b0;
        #1;
        chk("rst mid sum", bus.sum, 32'h0);
        chk("rst mid ofsign", bus.ofsign, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (bus.ofsign !== 32'h0 || bus.sum !== 32'h0) quiet = 1'b0;
        end
        chk("rst no completion", {31'd0, quiet}, 32'd1);
        run_calc("after_rst", 32'h11, 32'h22, 1'b0);
        chk("after_rst const sum", bus.sum, 32'h33);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
